data_fetch_ctrl: RTL

Sequencer and arbiter for the shared 1024×16 sample/label memory in the perceptron datapath. It sits between the memory and two requesters: the host loader, which writes Q9 fixed-point words, and the training engine, which consumes samples. A sweep streams each sample's feature words followed by its label over a valid/ready interface, with no bubbles under continuous ready. Loader writes are granted only while no sweep is active.

---
 rtl/data_fetch_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/data_fetch_ctrl.sv
// data_fetch_ctrl: arbitrates host loader writes against sample sweeps over a shared 1024x16 memory.
// Optional build macro SWEEP_CONT_EN: sweeps repeat epoch after epoch until a stop pulse.
module data_fetch_ctrl #(
  parameter int NFEAT  = 4,
  parameter int NSAMP  = 200,
  parameter int SIDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  input  logic              wr_req,
  input  logic [10:0]       wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_gnt,
  output logic [15:0]       out_data,
  output logic              out_last,
  output logic [SIDX_W-1:0] out_sidx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_ena,
  output logic              mem_wr_rd,
  output logic [10:0]       mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout
);
  localparam int WPS = NFEAT + 1;
  localparam int FW  = (WPS > 1) ? $clog2(WPS) : 1;
  localparam logic [10:0]       TOTAL     = 11'(NSAMP * WPS);
  localparam logic [FW-1:0]     LAST_FEAT = FW'(NFEAT);
  localparam logic [SIDX_W-1:0] LAST_SIDX = SIDX_W'(NSAMP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q;
  logic              start_pend_q;
  logic [10:0]       rd_addr_q;
  logic [FW-1:0]     rd_feat_q;
  logic [SIDX_W-1:0] rd_sidx_q;
  logic              inflight_q;
  logic              infl_last_q;
  logic [SIDX_W-1:0] infl_sidx_q;
  logic [15:0]       fifo_data_q [3];
  logic              fifo_last_q [3];
  logic [SIDX_W-1:0] fifo_sidx_q [3];
  logic [1:0]        head_q;
  logic [1:0]        tail_q;
  logic [1:0]        count_q;

  logic       pop;
  logic       rd_en;
  logic       rd_final;
  logic       go;
  logic [2:0] occ;

`ifdef SWEEP_CONT_EN
  logic stop_pend_q;
`else
  logic unused_stop;
  assign unused_stop = stop;
`endif

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words buffered plus the read still on its way back, net of this cycle's pop, must stay below 3.
  assign pop      = out_valid & out_ready;
  assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en    = (state_q == SWEEP) && (rd_addr_q < TOTAL) && (occ < 3'd3);
  assign rd_final = rd_en && (rd_addr_q == TOTAL - 11'd1);
  assign go       = (state_q == IDLE) && (start || start_pend_q) && !wr_req;

  assign wr_gnt    = rst_n && (state_q == IDLE) && wr_req;
  assign busy      = (state_q != IDLE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[head_q];
  assign out_last  = fifo_last_q[head_q];
  assign out_sidx  = fifo_sidx_q[head_q];
  assign done      = pop && out_last && (out_sidx == LAST_SIDX);

  always_comb begin
    mem_ena   = 1'b0;
    mem_wr_rd = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (wr_gnt) begin
      mem_ena   = 1'b1;
      mem_wr_rd = 1'b1;
      mem_addr  = wr_addr;
      mem_din   = wr_data;
    end else if (rd_en) begin
      mem_ena  = 1'b1;
      mem_addr = {1'b0, rd_addr_q[9:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_pend_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_feat_q    <= '0;
      rd_sidx_q    <= '0;
      inflight_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      infl_sidx_q  <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
        fifo_sidx_q[i] <= '0;
      end
`ifdef SWEEP_CONT_EN
      stop_pend_q  <= 1'b0;
`endif
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        infl_last_q <= (rd_feat_q == LAST_FEAT);
        infl_sidx_q <= rd_sidx_q;
        if (rd_final) begin
          rd_addr_q <= '0;
          rd_feat_q <= '0;
          rd_sidx_q <= '0;
        end else begin
          rd_addr_q <= rd_addr_q + 11'd1;
          if (rd_feat_q == LAST_FEAT) begin
            rd_feat_q <= '0;
            rd_sidx_q <= rd_sidx_q + SIDX_W'(1);
          end else begin
            rd_feat_q <= rd_feat_q + FW'(1);
          end
        end
      end

      if (inflight_q) begin
        fifo_data_q[tail_q] <= mem_dout;
        fifo_last_q[tail_q] <= infl_last_q;
        fifo_sidx_q[tail_q] <= infl_sidx_q;
        tail_q              <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          if (go) begin
            state_q      <= SWEEP;
            start_pend_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_feat_q    <= '0;
            rd_sidx_q    <= '0;
          end else if (start && wr_req) begin
            start_pend_q <= 1'b1;
          end
        end
        SWEEP: begin
`ifdef SWEEP_CONT_EN
          if (rd_final && (stop_pend_q || stop)) state_q <= DRAIN;
`else
          if (rd_final) state_q <= DRAIN;
`endif
        end
        DRAIN: begin
          // Leave only on the very last buffered word, so an earlier epoch's label cannot end the sweep.
          if (done && (count_q == 2'd1) && !inflight_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef SWEEP_CONT_EN
      if (state_q == IDLE) stop_pend_q <= 1'b0;
      else if (stop)       stop_pend_q <= 1'b1;
`endif
    end
  end
endmodule
